// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Pure definitions: no timing or flow-control behaviour of its own.
package pipe_ctrl_pkg;

  localparam int PAUSE_W = 6;

  // Bit 0 is the pc register, bit 5 the write-back hold.
  localparam int P_IF_ID  = 1;
  localparam int P_ID_EX  = 2;
  localparam int P_EX_MEM = 3;
  localparam int P_MEM_WB = 4;

  localparam logic [31:0] EXC_VECTOR    = 32'hBFC0_0380;
  localparam logic [31:0] REFILL_VECTOR = 32'hBFC0_0200;
  localparam logic [4:0]  TLBL_CODE     = 5'h02;
  localparam logic [4:0]  TLBS_CODE     = 5'h03;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_WAIT_IF = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    PK_NONE   = 2'd0,
    PK_BRANCH = 2'd1,
    PK_EXC    = 2'd2
  } pend_kind_t;

  function automatic logic [PAUSE_W-1:0] hold_upto(input int idx);
    logic [PAUSE_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAUSE_W; i++) begin
      if (i <= idx) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [PAUSE_W-1:0] STALL_NONE = '0;
  localparam logic [PAUSE_W-1:0] STALL_IF   = hold_upto(P_IF_ID);
  localparam logic [PAUSE_W-1:0] STALL_ID   = hold_upto(P_ID_EX);
  localparam logic [PAUSE_W-1:0] STALL_EX   = hold_upto(P_EX_MEM);
  localparam logic [PAUSE_W-1:0] STALL_MEM  = hold_upto(P_MEM_WB);

  function automatic logic is_tlb_miss(input logic [4:0] code);
    return (code == TLBL_CODE) || (code == TLBS_CODE);
  endfunction

endpackage

// File: rtl/pipe_ctrl_target.sv
// Redirect-target mux: branch fix-up, eret return, TLB refill or general vector.
// Purely combinational, zero latency, no flow control.
module pipe_ctrl_target
  import pipe_ctrl_pkg::*;
(
  input  logic        sel_branch,
  input  logic        is_eret,
  input  logic        exc_refill,
  input  logic [4:0]  exc_code,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] branch_target,
  output logic [31:0] target
);

  always_comb begin
    target = EXC_VECTOR;
    if (sel_branch) begin
      target = branch_target;
    end else if (is_eret) begin
      target = cp0_epc;
    end else if (exc_refill && is_tlb_miss(exc_code)) begin
      target = REFILL_VECTOR;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller; outputs are combinational in the same cycle.
// A redirect that meets an unabortable fetch is parked in WAIT_IF until if_busy drops.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_if,
  input  logic               req_id,
  input  logic               req_ex,
  input  logic               req_mem,
  input  logic               if_busy,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic               exc_refill,
  input  logic               is_eret,
  input  logic [31:0]        cp0_epc,
  input  logic               mispredict,
  input  logic [31:0]        branch_target,
  output logic [PAUSE_W-1:0] pause,
  output logic               clear,
  output logic               clear_if_id,
  output logic               redirect,
  output logic [31:0]        new_pc,
  output logic               busy_wait
);

  state_t     state;
  pend_kind_t pend_kind;
  logic [31:0] pend_pc;
  logic [31:0] target;

  logic               evt_take;
  logic               mis_take;
  logic [PAUSE_W-1:0] stall_pat;

  logic [PAUSE_W-1:0] pause_c;
  logic               clear_c;
  logic               clear_if_id_c;
  logic               redirect_c;
  logic [31:0]        new_pc_c;
  logic               busy_wait_c;

  // A MEM stall defers exceptions/eret: the faulting instruction is not yet committed.
  assign evt_take = (exc_valid | is_eret) & ~req_mem;
  assign mis_take = (state == ST_RUN) & mispredict & ~req_mem & ~req_ex & ~evt_take;

  always_comb begin
    stall_pat = STALL_NONE;
    if (req_mem)     stall_pat = STALL_MEM;
    else if (req_ex) stall_pat = STALL_EX;
    else if (req_id) stall_pat = STALL_ID;
    else if (req_if) stall_pat = STALL_IF;
  end

  pipe_ctrl_target u_target (
    .sel_branch    (~evt_take),
    .is_eret       (is_eret),
    .exc_refill    (exc_refill),
    .exc_code      (exc_code),
    .cp0_epc       (cp0_epc),
    .branch_target (branch_target),
    .target        (target)
  );

  always_comb begin
    pause_c       = STALL_NONE;
    clear_c       = 1'b0;
    clear_if_id_c = 1'b0;
    redirect_c    = 1'b0;
    new_pc_c      = 32'h0;
    busy_wait_c   = 1'b0;
    case (state)
      ST_RUN: begin
        if (evt_take) begin
          clear_c    = 1'b1;
          redirect_c = ~if_busy;
          new_pc_c   = if_busy ? 32'h0 : target;
        end else if (mis_take) begin
          // Only IF/ID holds the wrong path; the delay slot in ID moves on.
          clear_if_id_c = 1'b1;
          redirect_c    = ~if_busy;
          new_pc_c      = if_busy ? 32'h0 : target;
        end else begin
          pause_c = stall_pat;
        end
      end
      ST_WAIT_IF: begin
        pause_c       = STALL_IF;
        clear_if_id_c = 1'b1;
        busy_wait_c   = 1'b1;
        clear_c       = evt_take;
        if (!if_busy) begin
          redirect_c = 1'b1;
          new_pc_c   = evt_take ? target : pend_pc;
        end
      end
      default: ;
    endcase
  end

  assign pause       = rst ? pause_c       : '0;
  assign clear       = rst ? clear_c       : 1'b0;
  assign clear_if_id = rst ? clear_if_id_c : 1'b0;
  assign redirect    = rst ? redirect_c    : 1'b0;
  assign new_pc      = rst ? new_pc_c      : 32'h0;
  assign busy_wait   = rst ? busy_wait_c   : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      pend_pc   <= 32'h0;
      pend_kind <= PK_NONE;
    end else begin
      case (state)
        ST_RUN: begin
          if ((evt_take || mis_take) && if_busy) begin
            state     <= ST_WAIT_IF;
            pend_pc   <= target;
            pend_kind <= evt_take ? PK_EXC : PK_BRANCH;
          end
        end
        ST_WAIT_IF: begin
          if (!if_busy) begin
            state     <= ST_RUN;
            pend_kind <= PK_NONE;
          end else if (evt_take) begin
            pend_pc   <= target;
            pend_kind <= PK_EXC;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Nothing may stay pending once the controller is back in RUN.
  a_pend_clean: assert property (@(posedge clk) disable iff (!rst)
    (state == ST_RUN) |-> (pend_kind == PK_NONE));

endmodule
